// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Serialises instruction-fetch and load/store requests onto one
//            single-port memory, with fixed/round-robin priority and timeout.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_port_arbiter #(
    parameter int unsigned TIMEOUT  = 16,
    parameter bit          FAIR     = 1'b0,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        if_req_valid,
    input  logic [31:0] if_req_addr,
    output logic        if_req_ready,
    output logic        if_resp_valid,
    output logic [31:0] if_resp_data,

    input  logic        d_req_valid,
    input  logic        d_req_we,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    output logic        d_req_ready,
    output logic        d_resp_valid,
    output logic [31:0] d_resp_data,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,

    output logic        mem_timeout,
    output logic        busy
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    typedef enum logic [0:0] {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // The counter only ever reaches TIMEOUT-1 before the access ends.
    localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam bit          TO_EN    = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] CNT_LAST = TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

    state_t            state_q,         state_d;
    owner_t            owner_q,         owner_d;
    owner_t            last_grant_q,    last_grant_d;
    logic              we_q,            we_d;
    logic [31:0]       addr_q,          addr_d;
    logic [31:0]       wdata_q,         wdata_d;
    logic [CNT_W-1:0]  cnt_q,           cnt_d;
    logic              if_resp_valid_q, if_resp_valid_d;
    logic              d_resp_valid_q,  d_resp_valid_d;
    logic [31:0]       if_resp_data_q,  if_resp_data_d;
    logic [31:0]       d_resp_data_q,   d_resp_data_d;
    logic              mem_timeout_q,   mem_timeout_d;

    logic              grant_if;
    logic              grant_d;
    logic              expire;
    logic              finish;
    logic [31:0]       resp_value;

    // Grant decision; readys are also held low while reset is asserted.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if ((state_q == S_IDLE) && reset_n) begin
            if (d_req_valid && (!if_req_valid || !FAIR || (last_grant_q == OWN_IF))) begin
                grant_d = 1'b1;
            end else if (if_req_valid) begin
                grant_if = 1'b1;
            end
        end
    end

    // An ack in the expiry cycle wins over the abort.
    always_comb begin
        expire     = TO_EN && (state_q == S_BUSY) && !mem_ack && (cnt_q == CNT_LAST);
        finish     = (state_q == S_BUSY) && (mem_ack || expire);
        resp_value = we_q ? 32'h0 : (mem_ack ? mem_rdata : ERR_DATA);
    end

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        last_grant_d    = last_grant_q;
        we_d            = we_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        cnt_d           = cnt_q;
        if_resp_valid_d = 1'b0;
        d_resp_valid_d  = 1'b0;
        if_resp_data_d  = if_resp_data_q;
        d_resp_data_d   = d_resp_data_q;
        mem_timeout_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (grant_d || grant_if) begin
                    state_d      = S_BUSY;
                    owner_d      = grant_d ? OWN_D : OWN_IF;
                    last_grant_d = grant_d ? OWN_D : OWN_IF;
                    we_d         = grant_d && d_req_we;
                    addr_d       = grant_d ? d_req_addr : if_req_addr;
                    wdata_d      = grant_d ? d_req_wdata : 32'h0;
                    cnt_d        = '0;
                end
            end

            S_BUSY: begin
                if (finish) begin
                    state_d       = S_IDLE;
                    mem_timeout_d = expire;
                    if (owner_q == OWN_D) begin
                        d_resp_valid_d = 1'b1;
                        d_resp_data_d  = resp_value;
                    end else begin
                        if_resp_valid_d = 1'b1;
                        if_resp_data_d  = resp_value;
                    end
                end else if (TO_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            owner_q         <= OWN_IF;
            last_grant_q    <= OWN_IF;
            we_q            <= 1'b0;
            addr_q          <= 32'h0;
            wdata_q         <= 32'h0;
            cnt_q           <= '0;
            if_resp_valid_q <= 1'b0;
            d_resp_valid_q  <= 1'b0;
            if_resp_data_q  <= 32'h0;
            d_resp_data_q   <= 32'h0;
            mem_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            last_grant_q    <= last_grant_d;
            we_q            <= we_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            cnt_q           <= cnt_d;
            if_resp_valid_q <= if_resp_valid_d;
            d_resp_valid_q  <= d_resp_valid_d;
            if_resp_data_q  <= if_resp_data_d;
            d_resp_data_q   <= d_resp_data_d;
            mem_timeout_q   <= mem_timeout_d;
        end
    end

    assign if_req_ready  = grant_if;
    assign d_req_ready   = grant_d;
    assign if_resp_valid = if_resp_valid_q;
    assign if_resp_data  = if_resp_data_q;
    assign d_resp_valid  = d_resp_valid_q;
    assign d_resp_data   = d_resp_data_q;
    assign busy          = (state_q == S_BUSY);
    assign mem_req       = busy;
    assign mem_we        = busy && we_q;
    assign mem_addr      = busy ? addr_q  : 32'h0;
    assign mem_wdata     = busy ? wdata_q : 32'h0;
    assign mem_timeout   = mem_timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Self-checking bench for mem_port_arbiter (vector table plus
//            scoreboard of expected responses, with a simple memory model).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_port_arbiter;

    localparam logic [31:0] ERR = 32'hDEADBEEF;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
        logic        never;
        logic [31:0] exp_data;
        logic        exp_to;
        int          exp_cyc;
    } vec_t;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
        logic        to;
        int          cyc;
        logic        mwe;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        int          delay;
        logic        never;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_req_valid = 1'b0;
    logic [31:0] if_req_addr = 32'h0;
    logic        d_req_valid = 1'b0;
    logic        d_req_we = 1'b0;
    logic [31:0] d_req_addr = 32'h0;
    logic [31:0] d_req_wdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        force_ack = 1'b0;

    logic        a_if_req_ready, a_if_resp_valid, a_d_req_ready, a_d_resp_valid;
    logic [31:0] a_if_resp_data, a_d_resp_data, a_mem_addr, a_mem_wdata;
    logic        a_mem_req, a_mem_we, a_mem_timeout, a_busy;
    logic        b_if_req_ready, b_if_resp_valid, b_d_req_ready, b_d_resp_valid;
    logic [31:0] b_if_resp_data, b_d_resp_data, b_mem_addr, b_mem_wdata;
    logic        b_mem_req, b_mem_we, b_mem_timeout, b_busy;

    sb_t  sb_q[$];
    vec_t vecs[9];
    int   n_vec = 0;
    int   n_mis = 0;
    int   cyc = 0;
    int   busy_cyc = 0;
    int   req_cycles = 0;
    int   hs_cyc = 0;
    int   hs_first = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.TIMEOUT(4), .FAIR(1'b0), .ERR_DATA(32'hDEADBEEF)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(a_if_req_ready),
        .if_resp_valid(a_if_resp_valid), .if_resp_data(a_if_resp_data),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_ready(a_d_req_ready),
        .d_resp_valid(a_d_resp_valid), .d_resp_data(a_d_resp_data),
        .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_timeout(a_mem_timeout), .busy(a_busy)
    );

    mem_port_arbiter #(.TIMEOUT(0), .FAIR(1'b1), .ERR_DATA(32'hDEADBEEF)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(b_if_req_ready),
        .if_resp_valid(b_if_resp_valid), .if_resp_data(b_if_resp_data),
        .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_ready(b_d_req_ready),
        .d_resp_valid(b_d_resp_valid), .d_resp_data(b_d_resp_data),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_timeout(b_mem_timeout), .busy(b_busy)
    );

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return 32'h00310133 + (a - 32'h8) * 32'h9E3779B9;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: acks the access at the head of the scoreboard after its delay.
    always @(posedge clk) begin
        #1;
        if (a_mem_req) busy_cyc = busy_cyc + 1;
        else           busy_cyc = 0;
        mem_ack   = force_ack ||
                    (a_mem_req && (sb_q.size() > 0) && !sb_q[0].never && (busy_cyc == sb_q[0].delay));
        mem_rdata = mem_fn(a_mem_addr);
    end

    // Response monitor and memory-side stability checks for dut_a.
    always @(negedge clk) begin
        sb_t e;
        logic any_resp;
        if (!reset_n) begin
            sb_q.delete();
            req_cycles = 0;
        end else begin
            any_resp = a_if_resp_valid || a_d_resp_valid;
            if (a_mem_req) begin
                req_cycles = req_cycles + 1;
                check("mem_req_expected", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    check("mem_we", 32'(a_mem_we), 32'(sb_q[0].mwe));
                    check("mem_addr", a_mem_addr, sb_q[0].maddr);
                    check("mem_wdata", a_mem_wdata, sb_q[0].mwdata);
                end
            end
            if (any_resp) begin
                check("resp_single", 32'(a_if_resp_valid && a_d_resp_valid), 32'd0);
                check("resp_expected", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("resp_owner", 32'(a_d_resp_valid), 32'(e.is_d));
                    check("resp_data", e.is_d ? a_d_resp_data : a_if_resp_data, e.data);
                    check("mem_timeout", 32'(a_mem_timeout), 32'(e.to));
                    check("req_cycles", req_cycles, e.cyc);
                end
                req_cycles = 0;
            end else if (a_mem_timeout) begin
                check("timeout_spurious", 32'(a_mem_timeout), 32'd0);
            end
        end
    end

    task automatic issue(input vec_t v);
        int  n;
        bit  got;
        sb_t e;
        n = 0;
        got = 1'b0;
        if (v.is_d) begin
            d_req_valid = 1'b1; d_req_we = v.we; d_req_addr = v.addr; d_req_wdata = v.wdata;
        end else begin
            if_req_valid = 1'b1; if_req_addr = v.addr;
        end
        while (!got && n < 50) begin
            @(negedge clk);
            if (v.is_d ? a_d_req_ready : a_if_req_ready) got = 1'b1;
            else begin n++; @(posedge clk); #1; end
        end
        check("grant_wait", 32'(got), 32'd1);
        if (got) begin
            e = '{is_d: v.is_d, data: v.exp_data, to: v.exp_to, cyc: v.exp_cyc,
                  mwe: v.is_d && v.we, maddr: v.addr, mwdata: (v.is_d ? v.wdata : 32'h0),
                  delay: v.delay, never: v.never};
            sb_q.push_back(e);
            hs_cyc = cyc;
        end
        @(posedge clk); #1;
        // Scramble payload after the handshake: the DUT must hold its own copy.
        d_req_valid = 1'b0; if_req_valid = 1'b0;
        d_req_we = 1'($urandom); d_req_addr = $urandom; d_req_wdata = $urandom; if_req_addr = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || a_busy) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 32'((sb_q.size() == 0) && !a_busy), 32'd1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vecs[0] = '{1'b0, 1'b0, 32'h8,   32'h0,      2, 1'b0, 32'h00310133,  1'b0, 2};
        vecs[1] = '{1'b1, 1'b1, 32'h10,  32'h5,      3, 1'b0, 32'h0,         1'b0, 3};
        vecs[2] = '{1'b1, 1'b0, 32'h20,  32'h0,      1, 1'b1, ERR,           1'b1, 4};
        vecs[3] = '{1'b1, 1'b0, 32'h24,  32'h0,      4, 1'b0, mem_fn(32'h24), 1'b0, 4};
        vecs[4] = '{1'b1, 1'b0, 32'h28,  32'h0,      5, 1'b0, ERR,           1'b1, 4};
        vecs[5] = '{1'b1, 1'b1, 32'h2C,  32'hCAFE,   1, 1'b1, 32'h0,         1'b1, 4};
        vecs[6] = '{1'b0, 1'b0, 32'h100, 32'h0,      1, 1'b0, mem_fn(32'h100), 1'b0, 1};
        vecs[7] = '{1'b0, 1'b0, 32'h104, 32'h0,      1, 1'b1, ERR,           1'b1, 4};
        vecs[8] = '{1'b1, 1'b0, 32'h30,  32'h77,     1, 1'b0, mem_fn(32'h30), 1'b0, 1};

        // Reset state, with both requesters asserting valid.
        reset_n = 1'b0;
        if_req_valid = 1'b1;
        d_req_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_if_ready", 32'(a_if_req_ready), 32'd0);
        check("rst_d_ready", 32'(a_d_req_ready), 32'd0);
        check("rst_if_resp_valid", 32'(a_if_resp_valid), 32'd0);
        check("rst_d_resp_valid", 32'(a_d_resp_valid), 32'd0);
        check("rst_if_resp_data", a_if_resp_data, 32'h0);
        check("rst_d_resp_data", a_d_resp_data, 32'h0);
        check("rst_mem_req", 32'(a_mem_req), 32'd0);
        check("rst_mem_we", 32'(a_mem_we), 32'd0);
        check("rst_mem_addr", a_mem_addr, 32'h0);
        check("rst_mem_wdata", a_mem_wdata, 32'h0);
        check("rst_mem_timeout", 32'(a_mem_timeout), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        if_req_valid = 1'b0;
        d_req_valid = 1'b0;
        #2 reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            issue(vecs[i]);
            wait_idle();
        end

        // Timed-out load followed by a stray ack while idle.
        issue(vecs[2]);
        wait_idle();
        @(negedge clk); force_ack = 1'b1;
        @(negedge clk); force_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_ack_no_resp", 32'(a_d_resp_valid), 32'd0);
            check("late_ack_idle", 32'(a_busy), 32'd0);
        end
        @(posedge clk); #1;

        // Asynchronous reset in the middle of an access.
        v = '{1'b1, 1'b0, 32'h50, 32'h0, 1, 1'b1, ERR, 1'b1, 4};
        issue(v);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_mem_req", 32'(a_mem_req), 32'd0);
        check("mid_rst_busy", 32'(a_busy), 32'd0);
        check("mid_rst_mem_addr", a_mem_addr, 32'h0);
        check("mid_rst_d_resp_data", a_d_resp_data, 32'h0);
        check("mid_rst_if_resp_data", a_if_resp_data, 32'h0);
        check("mid_rst_mem_timeout", 32'(a_mem_timeout), 32'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_rst_no_resp", 32'(a_d_resp_valid), 32'd0);
            check("post_rst_idle", 32'(a_busy), 32'd0);
        end

        // Contention: dut_a fixed priority, dut_b round-robin, ack every first cycle.
        do_reset();
        d_req_we = 1'b0; d_req_addr = 32'h40; d_req_wdata = 32'h1234; if_req_addr = 32'h44;
        d_req_valid = 1'b1; if_req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("fix_if_ready", 32'(a_if_req_ready), 32'd0);
            check("fix_d_ready", 32'(a_d_req_ready), 32'((i % 2) == 0));
            check("rr_d_ready", 32'(b_d_req_ready), 32'((i % 4) == 0));
            check("rr_if_ready", 32'(b_if_req_ready), 32'((i % 4) == 2));
            if (a_d_req_ready) begin
                sb_q.push_back('{is_d: 1'b1, data: mem_fn(32'h40), to: 1'b0, cyc: 1, mwe: 1'b0,
                                 maddr: 32'h40, mwdata: 32'h1234, delay: 1, never: 1'b0});
            end
        end
        @(posedge clk); #1;
        d_req_valid = 1'b0; if_req_valid = 1'b0;
        wait_idle();

        // Back-to-back random traffic with single-cycle acks.
        for (int i = 0; i < 20; i++) begin
            v.is_d     = 1'($urandom_range(0, 1));
            v.we       = v.is_d ? 1'($urandom_range(0, 1)) : 1'b0;
            v.addr     = $urandom & 32'h0000_FFFC;
            v.wdata    = $urandom;
            v.delay    = 1;
            v.never    = 1'b0;
            v.exp_data = v.we ? 32'h0 : mem_fn(v.addr);
            v.exp_to   = 1'b0;
            v.exp_cyc  = 1;
            issue(v);
            if (i == 0) hs_first = hs_cyc;
        end
        check("b2b_spacing", hs_cyc - hs_first, 32'd38);
        wait_idle();

        check("sb_empty", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

`default_nettype wire
